// File: rtl/stream_pkg.sv
// Shared types for the BMP pixel-stream transmitter: pixel sizing, FSM states
// and the tagged pixel entry that flows through the skid buffer.
package stream_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int PIXEL_SIZE = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIXEL_SIZE-1:0] data;
    logic                  sol;
    logic                  sof;
  } skid_entry_t;

endpackage

// File: rtl/bmp_stream_tx_if.sv
// Bundle of control, frame-buffer read port and pixel-stream signals between
// the transmitter (master) and its environment (slave).
interface bmp_stream_tx_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DIM_WIDTH  = 12
);
  import stream_pkg::*;

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DIM_WIDTH-1:0]  width;
  logic [DIM_WIDTH-1:0]  height;
  logic [1:0]            padding;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [PIXEL_SIZE-1:0] mem_rdata;
  logic                  en;
  logic                  out_ready;
  logic                  hsync;
  logic                  vsync;
  logic [PIXEL_SIZE-1:0] data;
  logic                  busy;
  logic                  done;

  // Handshake: a pixel transfers on a cycle with en && out_ready; while en is
  // high and out_ready low, en/data/hsync/vsync hold their values unchanged.
  modport master (
    input  start, base_addr, width, height, padding, mem_rdata, out_ready,
    output mem_rd, mem_addr, en, hsync, vsync, data, busy, done
  );

  modport slave (
    output start, base_addr, width, height, padding, mem_rdata, out_ready,
    input  mem_rd, mem_addr, en, hsync, vsync, data, busy, done
  );

endinterface

// File: rtl/pixel_skid_buf.sv
// Two-entry pixel FIFO with valid/ready on both sides; when empty, an incoming
// entry falls straight through to the output in the same cycle.
module pixel_skid_buf
  import stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  skid_entry_t in_entry,
  output logic        out_valid,
  input  logic        out_ready,
  output skid_entry_t out_entry,
  output logic [1:0]  count
);

  skid_entry_t mem_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  cnt_q;
  logic        bypass;
  logic        push;
  logic        pop_store;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0) || in_valid;
  assign out_entry = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : in_entry;
  assign count     = cnt_q;

  // An entry consumed on the cycle it arrives into an empty buffer is never stored.
  assign bypass    = in_valid && (cnt_q == 2'd0) && out_ready;
  assign push      = in_valid && in_ready && !bypass;
  assign pop_store = out_ready && (cnt_q != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_store) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_store};
    end
  end

endmodule

// File: rtl/bmp_stream_tx.sv
// Streams one bottom-up BMP frame from a byte-addressed frame buffer as a
// pixel stream with hsync/vsync tags, one pixel per accepted cycle.
module bmp_stream_tx
  import stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DIM_WIDTH  = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  bmp_stream_tx_if.master bus,
  output state_t          dbg_state
);

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] STEP3   = 3;

  state_t                state_q;
  logic [DIM_WIDTH-1:0]  w_q, h_q, x_q, y_q;
  logic [1:0]            pad_q;
  logic [ADDR_WIDTH-1:0] addr_q, mem_addr_q;
  logic                  mem_rd_q, iss_sol_q, iss_sof_q;
  logic                  rvalid_q, r_sol_q, r_sof_q;

  logic [DIM_WIDTH-1:0]  cur_x, cur_y, cur_w, cur_h;
  logic [ADDR_WIDTH-1:0] cur_addr, pad_ext;
  logic [1:0]            cur_pad;
  logic                  start_ok, start_zero, slot_free, issue, row_end, frame_end, pop;
  logic [2:0]            stored_next;

  skid_entry_t sk_in, sk_out;
  logic        sk_in_ready, sk_out_valid;
  logic [1:0]  sk_count;

  // In IDLE the first pixel is issued straight from the start operands.
  always_comb begin
    cur_x    = x_q;
    cur_y    = y_q;
    cur_w    = w_q;
    cur_h    = h_q;
    cur_pad  = pad_q;
    cur_addr = addr_q;
    if (state_q == S_IDLE) begin
      cur_x    = '0;
      cur_y    = '0;
      cur_w    = bus.width;
      cur_h    = bus.height;
      cur_pad  = bus.padding;
      cur_addr = bus.base_addr;
    end
  end

  assign pad_ext     = {{(ADDR_WIDTH-2){1'b0}}, cur_pad};
  assign start_ok    = (state_q == S_IDLE) && bus.start;
  assign start_zero  = (bus.width == '0) || (bus.height == '0);
  assign pop         = sk_out_valid && bus.out_ready;
  assign stored_next = {1'b0, sk_count} + {2'b0, rvalid_q} - {2'b0, pop};
  // Buffered pixels plus reads in flight never exceed the two buffer slots.
  assign slot_free   = sk_in_ready && ((stored_next + {2'b0, mem_rd_q}) <= 3'd1);
  assign issue       = (start_ok && !start_zero) || ((state_q == S_FETCH) && slot_free);
  assign row_end     = (cur_x == cur_w - DIM_ONE);
  assign frame_end   = row_end && (cur_y == cur_h - DIM_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      pad_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      iss_sol_q  <= 1'b0;
      iss_sof_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      r_sol_q    <= 1'b0;
      r_sof_q    <= 1'b0;
    end else begin
      rvalid_q <= mem_rd_q;
      r_sol_q  <= iss_sol_q;
      r_sof_q  <= iss_sof_q;
      mem_rd_q <= issue;
      if (issue) begin
        mem_addr_q <= cur_addr;
        iss_sol_q  <= (cur_x == '0);
        iss_sof_q  <= (cur_x == '0) && (cur_y == '0);
        if (row_end) begin
          x_q    <= '0;
          y_q    <= cur_y + DIM_ONE;
          addr_q <= cur_addr + STEP3 + pad_ext;
        end else begin
          x_q    <= cur_x + DIM_ONE;
          y_q    <= cur_y;
          addr_q <= cur_addr + STEP3;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            w_q     <= bus.width;
            h_q     <= bus.height;
            pad_q   <= bus.padding;
            state_q <= (start_zero || frame_end) ? S_DRAIN : S_FETCH;
          end
        end
        S_FETCH: if (issue && frame_end) state_q <= S_DRAIN;
        S_DRAIN: if ((stored_next == 3'd0) && !mem_rd_q) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sk_in = {bus.mem_rdata, r_sol_q, r_sof_q};

  pixel_skid_buf u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rvalid_q),
    .in_ready  (sk_in_ready),
    .in_entry  (sk_in),
    .out_valid (sk_out_valid),
    .out_ready (bus.out_ready),
    .out_entry (sk_out),
    .count     (sk_count)
  );

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.en       = sk_out_valid;
  assign bus.data     = sk_out_valid ? sk_out.data : '0;
  assign bus.hsync    = sk_out_valid && sk_out.sol;
  assign bus.vsync    = sk_out_valid && sk_out.sof;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bmp_stream_tx.sv
// Directed bench for bmp_stream_tx: a frame-buffer model feeds reads, a frame
// model predicts the address and pixel streams, one monitor compares them.
`timescale 1ns/1ps
module tb_bmp_stream_tx;
  import stream_pkg::*;

  localparam int AW = 20;
  localparam int DW = 12;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_t dbg_state;

  bmp_stream_tx_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();

  bmp_stream_tx #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int issued = 0, accepted = 0, done_cnt = 0;
  int first_rd_cyc = -1, first_en_cyc = -1, first_busy_cyc = -1;
  int done_cyc = -1, last_acc_cyc = -1;
  bit prev_done = 1'b0;
  bit bp_mode = 1'b0;
  logic [3:0]    bp_pat = 4'b1001;
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] obs_addr[$];
  logic [AW-1:0] ea;
  logic [25:0]   exp_q[$];
  logic [25:0]   obs_pix[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame buffer model ----------------
  function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
    int unsigned v;
    v = int'(a) * 37 + 11;
    return v[7:0];
  endfunction

  function automatic logic [23:0] pix_at(input logic [AW-1:0] a);
    return {byte_at(a + 20'd2), byte_at(a + 20'd1), byte_at(a)};
  endfunction

  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? pix_at(bus.mem_addr) : 24'($urandom);

  // Expected stream: raster order over bottom-up rows, stride 3*w + pad.
  task automatic push_frame(input logic [AW-1:0] base, input int w, input int h, input int pad);
    logic [AW-1:0] a;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        a = base + AW'(y * (3 * w + pad) + 3 * x);
        exp_addr_q.push_back(a);
        exp_q.push_back({pix_at(a), (x == 0), (x == 0) && (y == 0)});
      end
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    end
  end

  task automatic start_frame(input logic [AW-1:0] base, input int w, input int h,
                             input int pad, input bit expect_accept, output int t);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.width     = DW'(w);
    bus.height    = DW'(h);
    bus.padding   = 2'(pad);
    t = cyc;
    if (expect_accept) begin
      first_rd_cyc = -1; first_en_cyc = -1; first_busy_cyc = -1; done_cyc = -1;
      obs_addr.delete();
      obs_pix.delete();
      push_frame(base, w, h, pad);
    end
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.width     = DW'($urandom);
    bus.height    = DW'($urandom);
    bus.padding   = 2'($urandom);
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (done_cyc < 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check(done_cyc >= 0, "done_timeout", 64'(n), 64'(max_cyc));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.busy && first_busy_cyc < 0) first_busy_cyc = cyc;
      if (bus.mem_rd) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        obs_addr.push_back(bus.mem_addr);
        issued++;
        if (exp_addr_q.size() == 0) check(1'b0, "unexpected_rd", 64'(bus.mem_addr), 64'(0));
        else begin
          ea = exp_addr_q.pop_front();
          check(bus.mem_addr == ea, "mem_addr", 64'(bus.mem_addr), 64'(ea));
        end
        check((issued - accepted) <= 2, "outstanding", 64'(issued - accepted), 64'(2));
      end
      if (bus.en) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (exp_q.size() == 0) check(1'b0, "unexpected_en", 64'(bus.data), 64'(0));
        else begin
          check({bus.data, bus.hsync, bus.vsync} == exp_q[0], "pixel",
                64'({bus.data, bus.hsync, bus.vsync}), 64'(exp_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            obs_pix.push_back({bus.data, bus.hsync, bus.vsync});
            accepted++;
            last_acc_cyc = cyc;
          end
        end
      end
      if (prev_done) check(!bus.busy, "busy_after_done", 64'(bus.busy), 64'(0));
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check(bus.busy && exp_q.size() == 0 && exp_addr_q.size() == 0, "done_state",
              64'(exp_q.size()), 64'(0));
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check_outputs_zero(input string name);
    check({bus.mem_rd, bus.mem_addr, bus.en, bus.hsync, bus.vsync, bus.data, bus.busy, bus.done} == '0,
          name, 64'({bus.mem_rd, bus.mem_addr, bus.en, bus.hsync, bus.vsync, bus.busy, bus.done}), 64'(0));
    check(dbg_state == S_IDLE, {name, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, acc0, d0, n;
    logic [7:0] hs, vs;
    bus.start = 1'b0; bus.base_addr = '0; bus.width = '0; bus.height = '0; bus.padding = '0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // 4x2, base 0x100, no padding, always ready; second start lands on done cycle.
    start_frame(20'h100, 4, 2, 0, 1'b1, t);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.base_addr = 20'h500; bus.width = 12'd2; bus.height = 12'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(50);
    repeat (3) @(posedge clk);
    check(first_busy_cyc == t + 1, "t1_busy_cyc", 64'(first_busy_cyc - t), 64'(1));
    check(first_rd_cyc == t + 1, "t1_first_rd", 64'(first_rd_cyc - t), 64'(1));
    check(first_en_cyc == t + 2, "t1_first_en", 64'(first_en_cyc - t), 64'(2));
    check(last_acc_cyc == t + 9, "t1_last_en", 64'(last_acc_cyc - t), 64'(9));
    check(done_cyc == t + 10, "t1_done_cyc", 64'(done_cyc - t), 64'(10));
    check(obs_pix.size() == 8, "t1_count", 64'(obs_pix.size()), 64'(8));
    check(obs_addr[4] == 20'h10C, "t1_row1_addr", 64'(obs_addr[4]), 64'h10C);
    check(obs_addr[7] == 20'h115, "t1_last_addr", 64'(obs_addr[7]), 64'h115);
    check(obs_pix[0][25:2] == 24'h55300B, "t1_pix0_data", 64'(obs_pix[0][25:2]), 64'h55300B);
    hs = '0; vs = '0;
    for (int i = 0; i < obs_pix.size() && i < 8; i++) begin
      hs[i] = obs_pix[i][1];
      vs[i] = obs_pix[i][0];
    end
    check(hs == 8'b0001_0001, "t1_hsync_pat", 64'(hs), 64'h11);
    check(vs == 8'b0000_0001, "t1_vsync_pat", 64'(vs), 64'h01);

    // 3x3, padding 3, base 0: row stride 12 bytes.
    start_frame(20'h0, 3, 3, 3, 1'b1, t);
    wait_done(60);
    check(obs_addr[0] == 20'h00, "t2_row0_addr", 64'(obs_addr[0]), 64'h00);
    check(obs_addr[3] == 20'h0C, "t2_row1_addr", 64'(obs_addr[3]), 64'h0C);
    check(obs_addr[6] == 20'h18, "t2_row2_addr", 64'(obs_addr[6]), 64'h18);
    check(obs_pix[3][25:2] == 24'h11ECC7, "t2_row1_data", 64'(obs_pix[3][25:2]), 64'h11ECC7);
    check(done_cyc == t + 11, "t2_done_cyc", 64'(done_cyc - t), 64'(11));

    // 4x2 under out_ready pattern 1,0,0,1.
    bp_mode = 1'b1;
    start_frame(20'h200, 4, 2, 1, 1'b1, t);
    wait_done(200);
    bp_mode = 1'b0;
    check(obs_pix.size() == 8, "t3_count", 64'(obs_pix.size()), 64'(8));
    check(done_cyc == last_acc_cyc + 1, "t3_done_after_last", 64'(done_cyc - last_acc_cyc), 64'(1));

    // Zero width: no reads, no pixels, done two cycles after start.
    start_frame(20'h300, 0, 5, 0, 1'b1, t);
    wait_done(20);
    check(done_cyc == t + 2, "t4_done_cyc", 64'(done_cyc - t), 64'(2));
    check(first_rd_cyc == -1, "t4_no_rd", 64'(first_rd_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check(first_en_cyc == -1, "t4_no_en", 64'(first_en_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset after pixel 3 of a 4x4 frame, then a fresh frame.
    start_frame(20'h80, 4, 4, 2, 1'b1, t);
    acc0 = accepted;
    n = 0;
    while (accepted < acc0 + 4 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check(accepted >= acc0 + 4, "t5_reach_pix3", 64'(accepted - acc0), 64'(4));
    #2;
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    exp_q.delete(); exp_addr_q.delete();
    issued = 0; accepted = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    check(done_cnt == d0, "t5_no_done", 64'(done_cnt - d0), 64'(0));
    start_frame(20'h80, 4, 4, 2, 1'b1, t);
    wait_done(60);
    check(obs_addr[0] == 20'h80, "t5_restart_addr", 64'(obs_addr[0]), 64'h80);
    check(obs_pix[0][0] == 1'b1, "t5_restart_vsync", 64'(obs_pix[0][0]), 64'(1));
    check(obs_pix.size() == 16, "t5_count", 64'(obs_pix.size()), 64'(16));
    check(done_cyc == t + 18, "t5_done_cyc", 64'(done_cyc - t), 64'(18));

    // Start while busy with another base is ignored.
    start_frame(20'h40, 4, 2, 0, 1'b1, t);
    start_frame(20'h300, 2, 2, 1, 1'b0, n);
    wait_done(60);
    check(obs_addr[0] == 20'h40, "t6_base_kept", 64'(obs_addr[0]), 64'h40);
    check(obs_pix.size() == 8, "t6_count", 64'(obs_pix.size()), 64'(8));
    check(done_cyc == t + 10, "t6_done_cyc", 64'(done_cyc - t), 64'(10));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
